// File: rtl/mux_arb_pkg.sv
// Shared types for the two-input stream merger: source select encoding.
// Provides sel_t (1 bit) plus the SEL_I0 / SEL_I1 constants.
package mux_arb_pkg;

    typedef logic sel_t;

    localparam sel_t SEL_I0 = 1'b0;
    localparam sel_t SEL_I1 = 1'b1;

endpackage

// File: rtl/rr_arb_2.sv
// Two-request arbiter; round-robin when MUX_2TO1_ARB_RR_EN, else i0 fixed.
// Ports: [clk, rst, take: RR build only], req0, req1, grant, grant_valid.
module rr_arb_2
    import mux_arb_pkg::*;
(
`ifdef MUX_2TO1_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output sel_t grant,
    output logic grant_valid
);

`ifdef MUX_2TO1_ARB_RR_EN
    sel_t prio;

    // After serving source k, the other source is preferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= SEL_I0;
        end else if (take) begin
            prio <= ~grant;
        end
    end
`else
    localparam sel_t prio = SEL_I0;
`endif

    always_comb begin
        grant_valid = req0 | req1;
        grant       = SEL_I0;
        if (req0 && req1) begin
            grant = prio;
        end else if (req1) begin
            grant = SEL_I1;
        end
    end

endmodule

// File: rtl/mux_2to1_arb.sv
// Two-source valid/ready merger with a one-entry registered output stage.
// Ports: clk, rst, i0/i1 (+valid/ready), o, o_valid, o_ready, o_sel.
// Round-robin arbitration is enabled by MUX_2TO1_ARB_RR_EN.
module mux_2to1_arb
    import mux_arb_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [width-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [width-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output sel_t             o_sel
);

    sel_t grant;
    logic grant_valid;
    logic free;
    logic take;

    // The stage can accept when empty or being drained this cycle.
    assign free = !o_valid || o_ready;
    assign take = free && grant_valid;

    assign i0_ready = take && (grant == SEL_I0);
    assign i1_ready = take && (grant == SEL_I1);

    rr_arb_2 u_arb (
`ifdef MUX_2TO1_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .take        (take),
`endif
        .req0        (i0_valid),
        .req1        (i1_valid),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o       <= '0;
            o_sel   <= SEL_I0;
            o_valid <= 1'b0;
        end else if (take) begin
            o       <= (grant == SEL_I1) ? i1 : i0;
            o_sel   <= grant;
            o_valid <= 1'b1;
        end else if (free) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Self-checking bench for mux_2to1_arb: queue-based model plus directed
// literal checks. Builds with or without MUX_2TO1_ARB_RR_EN.
module tb_mux_2to1_arb;
    import mux_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i0 = '0;
    logic        i0_valid = 1'b0;
    logic        i0_ready;
    logic [15:0] i1 = '0;
    logic        i1_valid = 1'b0;
    logic        i1_ready;
    logic [15:0] o;
    logic        o_valid;
    logic        o_ready = 1'b0;
    sel_t        o_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_2to1_arb #(.width(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1       (i1),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_sel    (o_sel)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: the output stage is a queue holding at most one beat.
    typedef struct {
        logic [15:0] d;
        logic        s;
    } beat_t;

    beat_t mq[$];
`ifdef MUX_2TO1_ARB_RR_EN
    logic m_prio = 1'b0;
`endif

    function automatic int winner();
        if (i0_valid && i1_valid) begin
`ifdef MUX_2TO1_ARB_RR_EN
            return int'(m_prio);
`else
            return 0;
`endif
        end
        if (i0_valid) return 0;
        if (i1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_free();
        return (mq.size() == 0) || (o_ready === 1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
`ifdef MUX_2TO1_ARB_RR_EN
            m_prio = 1'b0;
`endif
        end else if (m_free()) begin
            int w;
            beat_t b;
            w = winner();
            if (mq.size() != 0) void'(mq.pop_front());
            if (w >= 0) begin
                b.d = (w == 1) ? i1 : i0;
                b.s = (w == 1);
                mq.push_back(b);
`ifdef MUX_2TO1_ARB_RR_EN
                m_prio = ~b.s;
`endif
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int w;
        w = winner();
        chk("m_o_valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
        chk("m_i0_ready", {31'd0, i0_ready}, {31'd0, m_free() && w == 0});
        chk("m_i1_ready", {31'd0, i1_ready}, {31'd0, m_free() && w == 1});
        if (mq.size() != 0) begin
            chk("m_o", {16'd0, o}, {16'd0, mq[0].d});
            chk("m_o_sel", {31'd0, o_sel}, {31'd0, mq[0].s});
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    logic [15:0] exp_d[4];
    logic        exp_s[4];

    initial begin
`ifdef MUX_2TO1_ARB_RR_EN
        exp_d = '{16'hA000, 16'hB000, 16'hA000, 16'hB000};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{16'hA000, 16'hA000, 16'hA000, 16'hA000};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        // Reset state
        #12;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o", {16'd0, o}, 32'd0);
        chk("rst_o_sel", {31'd0, o_sel}, 32'd0);
        rst = 1'b0;

        // Single source
        i0 = 16'hA000;
        i0_valid = 1'b1;
        o_ready = 1'b1;
        #1;
        chk("single_i0_ready", {31'd0, i0_ready}, 32'd1);
        chk("single_i1_ready", {31'd0, i1_ready}, 32'd0);
        step();
        i0_valid = 1'b0;
        chk("single_o", {16'd0, o}, 32'hA000);
        chk("single_o_sel", {31'd0, o_sel}, 32'd0);
        chk("single_o_valid", {31'd0, o_valid}, 32'd1);
        step();
        chk("single_drain", {31'd0, o_valid}, 32'd0);

        // Contention after reset
        pulse_reset();
        i0 = 16'hA000;
        i1 = 16'hB000;
        i0_valid = 1'b1;
        i1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("cont_o_%0d", k), {16'd0, o}, {16'd0, exp_d[k]});
            chk($sformatf("cont_sel_%0d", k), {31'd0, o_sel},
                {31'd0, exp_s[k]});
        end
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        step();

        // Backpressure
        i0 = 16'h1234;
        i0_valid = 1'b1;
        step();
        chk("bp_load", {16'd0, o}, 32'h1234);
        i0_valid = 1'b0;
        o_ready = 1'b0;
        i1 = 16'hC000;
        i1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_i0_ready", {31'd0, i0_ready}, 32'd0);
            chk("bp_i1_ready", {31'd0, i1_ready}, 32'd0);
            step();
            chk("bp_hold_o", {16'd0, o}, 32'h1234);
            chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, i1_ready}, 32'd1);
        step();
        i1_valid = 1'b0;
        chk("bp_new_o", {16'd0, o}, 32'hC000);
        chk("bp_new_sel", {31'd0, o_sel}, 32'd1);

        // Idle drain
        i1 = 16'hD000;
        i1_valid = 1'b1;
        step();
        i1_valid = 1'b0;
        chk("drain_o", {16'd0, o}, 32'hD000);
        chk("drain_valid", {31'd0, o_valid}, 32'd1);
        step();
        chk("drain_empty", {31'd0, o_valid}, 32'd0);

        // Reset mid-stall; beat from i0 so a round-robin prio would be 1
        i0 = 16'hE000;
        i0_valid = 1'b1;
        step();
        i0_valid = 1'b0;
        o_ready = 1'b0;
        step();
        chk("stall_valid", {31'd0, o_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_o", {16'd0, o}, 32'd0);
        chk("arst_o_sel", {31'd0, o_sel}, 32'd0);
        rst = 1'b0;
        o_ready = 1'b1;
        i0 = 16'hA000;
        i1 = 16'hB000;
        i0_valid = 1'b1;
        i1_valid = 1'b1;
        #1;
        chk("post_rst_i0_ready", {31'd0, i0_ready}, 32'd1);
        chk("post_rst_i1_ready", {31'd0, i1_ready}, 32'd0);
        step();
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        chk("post_rst_o", {16'd0, o}, 32'hA000);
        chk("post_rst_sel", {31'd0, o_sel}, 32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
